usb_dev_state_ctrl: RTL
=======================

# usb_dev_state_ctrl

Parametrised USB 2.0 device-state controller for the hub/device core, covering the full Chapter 9 visible-state model: Attached, Powered, Default, Address, Configured and Suspended. It replaces the three-state default/address/configured tracker. It owns the device address, the active configuration value, deferred SET_ADDRESS commit, suspend detection and resume, and it acks or stalls standard requests forwarded by the control-endpoint decoder.

## Interface
Parameters:
- SUSPEND_CYCLES, 180000: consecutive bus-idle clocks before entering suspend (3 ms at 60 MHz); must be ≥2.
- NUM_CONFIGS, 1: highest valid bConfigurationValue (1..255).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- vbus  in  1  VBUS present (level, pre-synchronised)
- bus_reset  in  1  USB bus reset detected (1-cycle pulse)
- bus_idle  in  1  line in idle J state this cycle (level)
- set_addr_req  in  1  SET_ADDRESS setup decoded (pulse)
- set_addr_val  in  7  requested address, valid with set_addr_req
- set_cfg_req  in  1  SET_CONFIGURATION setup decoded (pulse)
- set_cfg_val  in  8  requested configuration value, valid with set_cfg_req
- status_done  in  1  control-transfer status stage completed (pulse)
- dev_state  out  3  0 ATTACHED, 1 POWERED, 2 DEFAULT, 3 ADDRESS, 4 CONFIGURED, 5 SUSPENDED
- dev_addr  out  7  active device address
- cfg_val  out  8  active configuration value
- is_conf  out  1  dev_state == CONFIGURED
- suspended  out  1  dev_state == SUSPENDED
- req_ack  out  1  request accepted (pulse)
- req_stall  out  1  request rejected (pulse)

## Operation
- Reset values: dev_state ATTACHED, dev_addr 0, cfg_val 0, is_conf 0, suspended 0, req_ack 0, req_stall 0. The pending-address register, its valid flag, the idle counter and the saved state are all cleared.
- Event priority, highest first: rst_n, then !vbus, then bus_reset, then suspend/resume, then requests, then status_done.
- !vbus: any state goes to ATTACHED. Clear addr, cfg, pending and counter.
- ATTACHED with vbus=1 goes to POWERED.
- bus_reset with vbus=1: any state (including SUSPENDED and POWERED) goes to DEFAULT. Clear addr, cfg, pending and counter. Any request in the same cycle is dropped with no ack and no stall.
- Suspend: in POWERED, DEFAULT, ADDRESS or CONFIGURED, the counter increments on each bus_idle=1 cycle and clears on bus_idle=0. When the counter equals SUSPEND_CYCLES-1 and bus_idle=1, save the current state and go to SUSPENDED. The counter saturates and is cleared on entry.
- Resume: in SUSPENDED, a cycle with bus_idle=0 restores the saved state. dev_addr and cfg_val are unchanged through suspend.
- SET_ADDRESS:
  - Accepted in DEFAULT or ADDRESS: latch set_addr_val into pending, set pending valid, pulse req_ack.
  - Rejected with req_stall in POWERED, CONFIGURED and SUSPENDED.
  - The address does not change until the next status_done with pending valid. On that status_done: dev_addr <= pending; state becomes ADDRESS if pending≠0, else DEFAULT; pending valid clears.
  - status_done with pending invalid is ignored.
  - A new SET_ADDRESS overwrites pending.
- SET_CONFIGURATION (effective immediately; no status wait):
  - ADDRESS, val 0: ack, cfg_val stays 0, remain in ADDRESS.
  - ADDRESS, val 1..NUM_CONFIGS: ack, cfg_val <= val, go to CONFIGURED.
  - CONFIGURED, val 0: ack, cfg_val <= 0, go to ADDRESS.
  - CONFIGURED, valid nonzero val: ack, cfg_val <= val, stay in CONFIGURED.
  - val > NUM_CONFIGS: stall, no change.
  - DEFAULT, POWERED or SUSPENDED: stall.
- set_addr_req and set_cfg_req in the same cycle: single req_stall, neither applied.
- req_ack and req_stall are mutually exclusive.

## Timing
- All outputs are registered.
- A request at edge N produces req_ack or req_stall high for exactly cycle N+1. dev_state, cfg_val and the pending address update on the same edge.
- status_done at edge N updates dev_addr and dev_state on the same edge. The new address is visible from cycle N+1.
- bus_idle held high from cycle 0 in an active state gives suspended=1 after exactly SUSPEND_CYCLES edges.
- Resume, vbus loss, bus_reset and ATTACHED→POWERED each take effect one edge after the cause.
- rst_n low mid-operation at any edge forces the reset values on that edge. Pending requests are discarded and no ack is emitted.

## Test plan
- Enumeration, NUM_CONFIGS=2:
  - vbus=1 → POWERED.
  - bus_reset → DEFAULT.
  - SET_ADDRESS 0x15 → req_ack, dev_addr still 0.
  - status_done → ADDRESS, dev_addr=0x15.
  - SET_CONFIGURATION 2 → CONFIGURED, cfg_val=2, is_conf=1.
- Invalid requests:
  - SET_CONFIGURATION 3 with NUM_CONFIGS=2 → req_stall, state unchanged.
  - SET_ADDRESS in CONFIGURED → req_stall.
  - Simultaneous set_addr_req and set_cfg_req → one req_stall.
- Deconfigure and zero address:
  - In CONFIGURED, SET_CONFIGURATION 0 → ADDRESS, cfg_val=0.
  - SET_ADDRESS 0 then status_done → DEFAULT, dev_addr=0.
- Suspend/resume, SUSPEND_CYCLES=8:
  - From CONFIGURED, bus_idle high for 7 cycles then low → no suspend.
  - bus_idle high for 8 cycles → suspended=1.
  - bus_idle low → CONFIGURED, cfg_val retained.
- bus_reset while SUSPENDED with pending address → DEFAULT, dev_addr=0, cfg_val=0, later status_done ignored.
- vbus dropped in CONFIGURED → ATTACHED, all registers cleared. rst_n asserted mid-request → no req_ack, reset values next cycle.

Source files
------------

// File: rtl/usb_dev_state_ctrl.sv
// USB 2.0 device-state controller: tracks the Chapter 9 visible states, owns the device
// address and configuration value, and acks or stalls standard requests from the EP0 decoder.
module usb_dev_state_ctrl #(
    parameter int SUSPEND_CYCLES = 180000,
    parameter int NUM_CONFIGS    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vbus,
    input  logic       bus_reset,
    input  logic       bus_idle,
    input  logic       set_addr_req,
    input  logic [6:0] set_addr_val,
    input  logic       set_cfg_req,
    input  logic [7:0] set_cfg_val,
    input  logic       status_done,
    output logic [2:0] dev_state,
    output logic [6:0] dev_addr,
    output logic [7:0] cfg_val,
    output logic       is_conf,
    output logic       suspended,
    output logic       req_ack,
    output logic       req_stall
);

    typedef enum logic [2:0] {
        ST_ATTACHED   = 3'd0,
        ST_POWERED    = 3'd1,
        ST_DEFAULT    = 3'd2,
        ST_ADDRESS    = 3'd3,
        ST_CONFIGURED = 3'd4,
        ST_SUSPENDED  = 3'd5
    } state_t;

    localparam int               CNT_W    = $clog2(SUSPEND_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SUSPEND_CYCLES - 1);
    localparam logic [7:0]       MAX_CFG  = 8'(NUM_CONFIGS);

    state_t           state, state_nxt, saved_state, saved_nxt;
    logic [6:0]       addr_nxt, pend_addr, pend_addr_nxt;
    logic [7:0]       cfg_nxt;
    logic             pend_valid, pend_valid_nxt;
    logic [CNT_W-1:0] idle_cnt, cnt_nxt;
    logic             ack_nxt, stall_nxt;

    assign dev_state = state;

    // Each cycle only the highest-priority event is acted on; lower ones are dropped.
    always_comb begin
        state_nxt      = state;
        saved_nxt      = saved_state;
        addr_nxt       = dev_addr;
        cfg_nxt        = cfg_val;
        pend_addr_nxt  = pend_addr;
        pend_valid_nxt = pend_valid;
        cnt_nxt        = idle_cnt;
        ack_nxt        = 1'b0;
        stall_nxt      = 1'b0;

        if (!vbus) begin
            state_nxt      = ST_ATTACHED;
            addr_nxt       = '0;
            cfg_nxt        = '0;
            pend_addr_nxt  = '0;
            pend_valid_nxt = 1'b0;
            cnt_nxt        = '0;
        end else if (bus_reset) begin
            state_nxt      = ST_DEFAULT;
            addr_nxt       = '0;
            cfg_nxt        = '0;
            pend_addr_nxt  = '0;
            pend_valid_nxt = 1'b0;
            cnt_nxt        = '0;
        end else if (state == ST_ATTACHED) begin
            state_nxt = ST_POWERED;
        end else if (state == ST_SUSPENDED && !bus_idle) begin
            state_nxt = saved_state;
        end else if (state != ST_SUSPENDED && bus_idle && idle_cnt == CNT_LAST) begin
            saved_nxt = state;
            state_nxt = ST_SUSPENDED;
            cnt_nxt   = '0;
        end else begin
            if (state != ST_SUSPENDED)
                cnt_nxt = bus_idle ? idle_cnt + CNT_W'(1) : '0;

            if (set_addr_req && set_cfg_req) begin
                stall_nxt = 1'b1;
            end else if (set_addr_req) begin
                if (state == ST_DEFAULT || state == ST_ADDRESS) begin
                    pend_addr_nxt  = set_addr_val;
                    pend_valid_nxt = 1'b1;
                    ack_nxt        = 1'b1;
                end else begin
                    stall_nxt = 1'b1;
                end
            end else if (set_cfg_req) begin
                if (set_cfg_val > MAX_CFG || !(state == ST_ADDRESS || state == ST_CONFIGURED)) begin
                    stall_nxt = 1'b1;
                end else begin
                    ack_nxt   = 1'b1;
                    cfg_nxt   = set_cfg_val;
                    state_nxt = (set_cfg_val == 8'd0) ? ST_ADDRESS : ST_CONFIGURED;
                end
            end else if (status_done && pend_valid && state != ST_SUSPENDED) begin
                // Deferred SET_ADDRESS commit; address 0 drops back to DEFAULT
                addr_nxt       = pend_addr;
                pend_valid_nxt = 1'b0;
                state_nxt      = (pend_addr != 7'd0) ? ST_ADDRESS : ST_DEFAULT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_ATTACHED;
            saved_state <= ST_ATTACHED;
            dev_addr    <= '0;
            cfg_val     <= '0;
            pend_addr   <= '0;
            pend_valid  <= 1'b0;
            idle_cnt    <= '0;
            is_conf     <= 1'b0;
            suspended   <= 1'b0;
            req_ack     <= 1'b0;
            req_stall   <= 1'b0;
        end else begin
            state       <= state_nxt;
            saved_state <= saved_nxt;
            dev_addr    <= addr_nxt;
            cfg_val     <= cfg_nxt;
            pend_addr   <= pend_addr_nxt;
            pend_valid  <= pend_valid_nxt;
            idle_cnt    <= cnt_nxt;
            is_conf     <= (state_nxt == ST_CONFIGURED);
            suspended   <= (state_nxt == ST_SUSPENDED);
            req_ack     <= ack_nxt;
            req_stall   <= stall_nxt;
        end
    end

endmodule
